// File: rtl/sim_frame_tracker.sv
// sim_frame_tracker: counts video frames from vs falling edges and opens a
// register-dump window over a configurable frame range. A small FSM
// (IDLE -> ARMED -> DUMP -> DONE) controls the window, optionally held
// off until a ROM download completes.
// Optional build macro FRAME_LIMIT_EN: raises a sticky sim_finish when
// frame_cnt reaches MAX_FRAMES; without it sim_finish is tied low.
module sim_frame_tracker #(
  parameter int unsigned START_FRAME = 0,
  parameter int unsigned DUMP_FRAMES = 0,
  parameter bit          WAIT_DWNLD  = 1'b0,
  parameter logic [31:0] MAX_FRAMES  = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        vs,
  input  logic        dwnld,
  output logic [31:0] frame_cnt,
  output logic        vs_fall,
  output logic        dump_on,
  output logic        dump_start,
  output logic        sim_finish,
  output logic [1:0]  st
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    DUMP  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [31:0] START_M1 = 32'(START_FRAME) - 32'd1;
  localparam logic [31:0] DUMP_LEN = 32'(DUMP_FRAMES);

  // A frame limit of zero can never be reached since frame_cnt starts at 0.
  if (MAX_FRAMES == 32'd0) begin : g_bad_max_frames
    $error("sim_frame_tracker: MAX_FRAMES must be nonzero");
  end

  logic        vs_l;
  logic        dw_l;
  logic        vs_ok;
  logic        vs_fall_det;
  logic        dw_fall;
  logic        dw_rise;
  logic        start_hit;
  logic [31:0] frame_nxt;
  logic [31:0] dump_cnt;
  logic [31:0] dump_cnt_nxt;
  logic        dump_on_nxt;
  logic        dump_start_nxt;
  state_t      state;
  state_t      state_nxt;

  // Edge detection. vs_ok blocks a spurious fall when vs is already low at
  // reset release: a fall only counts once vs has been seen high.
  assign vs_fall_det = vs_ok & vs_l & ~vs;
  assign dw_fall     = dw_l & ~dwnld;
  assign dw_rise     = ~dw_l & dwnld;

  // Saturating increment of the frame counter.
  assign frame_nxt = (frame_cnt == 32'hFFFF_FFFF) ? frame_cnt : frame_cnt + 32'd1;

  // Dump-start condition: immediate when START_FRAME is 0, otherwise on the
  // vs fall that makes frame_cnt equal START_FRAME.
  assign start_hit = (START_FRAME == 0) ? 1'b1
                                        : (vs_fall_det && (frame_cnt == START_M1));

  // Input sampling, vs_fall pulse and frame counting (all states).
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // sees the pre-edge values of the others, independent of statement order.
    if (!rst_n) begin
      vs_l      <= 1'b1;
      dw_l      <= 1'b0;
      vs_ok     <= 1'b0;
      vs_fall   <= 1'b0;
      frame_cnt <= 32'd0;
    end else begin
      vs_l    <= vs;
      dw_l    <= dwnld;
      vs_ok   <= vs_ok | vs;
      vs_fall <= vs_fall_det;
      if (vs_fall_det) frame_cnt <= frame_nxt;
    end
  end

  // FSM state register plus the registered dump outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      dump_on    <= 1'b0;
      dump_start <= 1'b0;
      dump_cnt   <= 32'd0;
    end else begin
      state      <= state_nxt;
      dump_on    <= dump_on_nxt;
      dump_start <= dump_start_nxt;
      dump_cnt   <= dump_cnt_nxt;
    end
  end

  // Next-state and next-output logic; a download restart overrides all else.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a variable unassigned, which would otherwise infer a latch.
    state_nxt      = state;
    dump_on_nxt    = dump_on;
    dump_start_nxt = 1'b0;
    dump_cnt_nxt   = dump_cnt;

    case (state)
      IDLE: begin
        if (!WAIT_DWNLD || dw_fall) state_nxt = ARMED;
      end
      ARMED: begin
        if (start_hit) begin
          state_nxt      = DUMP;
          dump_on_nxt    = 1'b1;
          dump_start_nxt = 1'b1;
          dump_cnt_nxt   = 32'd0;
        end
      end
      DUMP: begin
        if (vs_fall_det) begin
          dump_cnt_nxt = dump_cnt + 32'd1;
          if ((DUMP_FRAMES != 0) && (dump_cnt + 32'd1 == DUMP_LEN)) begin
            state_nxt   = DONE;
            dump_on_nxt = 1'b0;
          end
        end
      end
      default: ; // DONE holds until reset or a download restart
    endcase

    if (WAIT_DWNLD && dw_rise && (state != IDLE)) begin
      state_nxt      = IDLE;
      dump_on_nxt    = 1'b0;
      dump_start_nxt = 1'b0;
    end
  end

  assign st = state;

`ifdef FRAME_LIMIT_EN
  // Sticky end-of-simulation request once frame_cnt reaches MAX_FRAMES.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sim_finish <= 1'b0;
    end else if (vs_fall_det && (frame_nxt == MAX_FRAMES)) begin
      sim_finish <= 1'b1;
    end
  end
`else
  assign sim_finish = 1'b0;
`endif

endmodule

// File: tb/tb_sim_frame_tracker.sv
// Directed bench for sim_frame_tracker. Four instances share clk/rst_n/vs:
//   dut0 defaults, dut1 START_FRAME=5/DUMP_FRAMES=2, dut2 WAIT_DWNLD=1,
//   dut3 MAX_FRAMES=4 (sim_finish expectation follows FRAME_LIMIT_EN).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_sim_frame_tracker;

`ifdef FRAME_LIMIT_EN
  localparam bit LIMIT_ON = 1'b1;
`else
  localparam bit LIMIT_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic vs;
  logic dwnld0;
  logic dwnld2;

  logic [31:0] frame_cnt0, frame_cnt1, frame_cnt2, frame_cnt3;
  logic        vs_fall0, vs_fall1, vs_fall2, vs_fall3;
  logic        dump_on0, dump_on1, dump_on2, dump_on3;
  logic        dump_start0, dump_start1, dump_start2, dump_start3;
  logic        sim_finish0, sim_finish1, sim_finish2, sim_finish3;
  logic [1:0]  st0, st1, st2, st3;

  int n_vec  = 0;
  int n_miss = 0;
  int n_vs_fall0 = 0;
  int n_dump_start0 = 0;

  always #5 clk = ~clk;

  sim_frame_tracker dut0 (
    .clk(clk), .rst_n(rst_n), .vs(vs), .dwnld(dwnld0),
    .frame_cnt(frame_cnt0), .vs_fall(vs_fall0), .dump_on(dump_on0),
    .dump_start(dump_start0), .sim_finish(sim_finish0), .st(st0)
  );

  sim_frame_tracker #(.START_FRAME(5), .DUMP_FRAMES(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .vs(vs), .dwnld(dwnld0),
    .frame_cnt(frame_cnt1), .vs_fall(vs_fall1), .dump_on(dump_on1),
    .dump_start(dump_start1), .sim_finish(sim_finish1), .st(st1)
  );

  sim_frame_tracker #(.WAIT_DWNLD(1'b1)) dut2 (
    .clk(clk), .rst_n(rst_n), .vs(vs), .dwnld(dwnld2),
    .frame_cnt(frame_cnt2), .vs_fall(vs_fall2), .dump_on(dump_on2),
    .dump_start(dump_start2), .sim_finish(sim_finish2), .st(st2)
  );

  sim_frame_tracker #(.MAX_FRAMES(32'd4)) dut3 (
    .clk(clk), .rst_n(rst_n), .vs(vs), .dwnld(dwnld0),
    .frame_cnt(frame_cnt3), .vs_fall(vs_fall3), .dump_on(dump_on3),
    .dump_start(dump_start3), .sim_finish(sim_finish3), .st(st3)
  );

  // Pulse-width counters for dut0 (cycles each output is seen high).
  always @(negedge clk) begin
    if (rst_n && vs_fall0)    n_vs_fall0++;
    if (rst_n && dump_start0) n_dump_start0++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // vs goes low; on return the detecting edge has happened.
  task automatic drop_vs();
    vs = 1'b0;
    @(negedge clk);
  endtask

  // Hold vs low one more cycle, then high for one cycle.
  task automatic raise_vs();
    @(negedge clk);
    vs = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n  = 1'b0;
    vs     = 1'b1;
    dwnld0 = 1'b0;
    dwnld2 = 1'b1;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst frame_cnt", frame_cnt0, 32'd0);
    check("rst vs_fall", {31'd0, vs_fall0}, 32'd0);
    check("rst dump_on", {31'd0, dump_on0}, 32'd0);
    check("rst dump_start", {31'd0, dump_start0}, 32'd0);
    check("rst sim_finish", {31'd0, sim_finish3}, 32'd0);
    check("rst st", {30'd0, st0}, 32'd0);

    // Release: dut0 IDLE -> ARMED -> DUMP
    rst_n = 1'b1;
    @(negedge clk);
    check("c1 st0", {30'd0, st0}, 32'd1);
    check("c1 dump_on0", {31'd0, dump_on0}, 32'd0);
    @(negedge clk);
    check("c2 st0", {30'd0, st0}, 32'd2);
    check("c2 dump_on0", {31'd0, dump_on0}, 32'd1);
    check("c2 dump_start0", {31'd0, dump_start0}, 32'd1);
    @(negedge clk);
    check("c3 dump_start0", {31'd0, dump_start0}, 32'd0);
    check("c3 st1 armed", {30'd0, st1}, 32'd1);

    // dut2 waits in IDLE through the download, arms on its fall
    repeat (97) @(negedge clk);
    check("dl st2 idle", {30'd0, st2}, 32'd0);
    dwnld2 = 1'b0;
    @(negedge clk);
    check("dl-fall st2", {30'd0, st2}, 32'd1);
    @(negedge clk);
    check("dl st2 dump", {30'd0, st2}, 32'd2);
    check("dl dump_on2", {31'd0, dump_on2}, 32'd1);

    // Seven frames
    for (int f = 1; f <= 7; f++) begin
      drop_vs();
      check($sformatf("f%0d frame_cnt0", f), frame_cnt0, 32'(f));
      check($sformatf("f%0d vs_fall0", f), {31'd0, vs_fall0}, 32'd1);
      check($sformatf("f%0d st1", f), {30'd0, st1}, (f < 5) ? 32'd1 : (f < 7) ? 32'd2 : 32'd3);
      check($sformatf("f%0d dump_on1", f), {31'd0, dump_on1}, (f == 5 || f == 6) ? 32'd1 : 32'd0);
      check($sformatf("f%0d dump_start1", f), {31'd0, dump_start1}, (f == 5) ? 32'd1 : 32'd0);
      check($sformatf("f%0d sim_finish3", f), {31'd0, sim_finish3}, (LIMIT_ON && f >= 4) ? 32'd1 : 32'd0);
      check($sformatf("f%0d sim_finish0", f), {31'd0, sim_finish0}, 32'd0);
      raise_vs();
      check($sformatf("f%0d vs_fall0 pulses", f), 32'(n_vs_fall0), 32'(f));
    end
    check("one dump_start0", 32'(n_dump_start0), 32'd1);
    check("frame_cnt1", frame_cnt1, 32'd7);

    // Download restart during DUMP
    dwnld2 = 1'b1;
    @(negedge clk);
    check("dl-rise st2", {30'd0, st2}, 32'd0);
    check("dl-rise dump_on2", {31'd0, dump_on2}, 32'd0);
    check("dl-rise frame_cnt2", frame_cnt2, 32'd7);

    // Reset mid-DUMP with vs low
    vs    = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check("mid rst frame_cnt0", frame_cnt0, 32'd0);
    check("mid rst vs_fall0", {31'd0, vs_fall0}, 32'd0);
    check("mid rst dump_on0", {31'd0, dump_on0}, 32'd0);
    check("mid rst dump_start0", {31'd0, dump_start0}, 32'd0);
    check("mid rst st0", {30'd0, st0}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel st0", {30'd0, st0}, 32'd1);
    check("rel dump_start0", {31'd0, dump_start0}, 32'd0);
    check("rel frame_cnt0", frame_cnt0, 32'd0);
    check("rel vs_fall0", {31'd0, vs_fall0}, 32'd0);
    repeat (3) @(negedge clk);
    check("low vs frame_cnt0", frame_cnt0, 32'd0);
    vs = 1'b1;
    @(negedge clk);
    drop_vs();
    check("post-rst frame_cnt0", frame_cnt0, 32'd1);
    check("post-rst vs_fall0", {31'd0, vs_fall0}, 32'd1);
    raise_vs();

    // Saturation
    force dut0.frame_cnt = 32'hFFFF_FFFE;
    @(negedge clk);
    release dut0.frame_cnt;
    drop_vs();
    check("sat frame_cnt0 a", frame_cnt0, 32'hFFFF_FFFF);
    raise_vs();
    drop_vs();
    check("sat frame_cnt0 b", frame_cnt0, 32'hFFFF_FFFF);
    check("sat vs_fall0", {31'd0, vs_fall0}, 32'd1);
    raise_vs();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/sim_frame_tracker.md
SIM_FRAME_TRACKER -- requirements
Module: sim_frame_tracker

Interface
REQ-001 SHALL have parameter START_FRAME, default 0: frame number at which dumping begins.
REQ-002 SHALL have parameter DUMP_FRAMES, default 0: number of frames to dump; 0 means unlimited.
REQ-003 SHALL have parameter WAIT_DWNLD, default 0: when 1, tracking is held until a ROM download completes.
REQ-004 SHALL have parameter MAX_FRAMES, default 32'hFFFF_FFFF: frame limit used by the FRAME_LIMIT_EN option.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all logic SHALL be clocked on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-007 SHALL have port vs, input, 1 bit: vertical sync; a falling edge marks the end of a frame.
REQ-008 SHALL have port dwnld, input, 1 bit: high while a ROM download is in progress.
REQ-009 SHALL have port frame_cnt, output, 32 bits: count of completed frames, feeding the dump controller.
REQ-010 SHALL have port vs_fall, output, 1 bit: one-cycle pulse for each detected vs falling edge.
REQ-011 SHALL have port dump_on, output, 1 bit: high while the dump window is open.
REQ-012 SHALL have port dump_start, output, 1 bit: one-cycle pulse when dump_on rises.
REQ-013 SHALL have port sim_finish, output, 1 bit: simulation-end request.
REQ-014 SHALL have port st, output, 2 bits: current state (IDLE=0, ARMED=1, DUMP=2, DONE=3).

Function
REQ-015 SHALL register vs into vs_l and dwnld into dw_l every cycle.
REQ-016 SHALL raise vs_fall for exactly one cycle after the clock edge that sampled vs_l=1 and vs=0.
REQ-017 SHALL increment frame_cnt on that same edge, saturating at 32'hFFFF_FFFF.
REQ-018 SHALL count frames in every state.
REQ-019 In IDLE with WAIT_DWNLD=0, SHALL move to ARMED on the first cycle after reset.
REQ-020 In IDLE with WAIT_DWNLD=1, SHALL move to ARMED only on a dwnld falling edge (dw_l=1, dwnld=0).
REQ-021 In ARMED with START_FRAME=0, SHALL move to DUMP on the next cycle.
REQ-022 In ARMED with START_FRAME>0, SHALL move to DUMP on the edge where the vs falling edge is detected and pre-increment frame_cnt==START_FRAME-1, so dump_on rises together with frame_cnt becoming START_FRAME.
REQ-023 On the ARMED-to-DUMP edge, SHALL set dump_on=1 and pulse dump_start for one cycle.
REQ-024 In DUMP, SHALL use an internal 32-bit counter, cleared on entry, that increments per vs falling edge.
REQ-025 With DUMP_FRAMES≠0, SHALL move from DUMP to DONE on the edge where that counter would reach DUMP_FRAMES, clearing dump_on.
REQ-026 SHALL hold DONE until reset, or until REQ-027 applies.
REQ-027 With WAIT_DWNLD=1, a dwnld rising edge in ARMED, DUMP or DONE SHALL force IDLE and clear dump_on; frame_cnt is unaffected.
REQ-028 If a dwnld rising edge and a dump-start condition coincide, the dwnld rising edge SHALL win: state goes to IDLE and there is no dump_start.
REQ-029 All outputs SHALL be registered.

Reset
REQ-030 rst_n=0 at a clock edge SHALL force frame_cnt=0, vs_fall=0, dump_on=0, dump_start=0, sim_finish=0, st=IDLE, vs_l=1, dw_l=0, and clear the internal dump counter.
REQ-031 Reset asserted mid-DUMP SHALL drop dump_on on the same edge, with no dump_start on release.
REQ-032 The first vs falling edge SHALL NOT count when vs is low at reset release.

Configuration
REQ-033 With macro FRAME_LIMIT_EN defined, SHALL set sim_finish=1 (sticky until reset) on the edge where frame_cnt becomes MAX_FRAMES.
REQ-034 With FRAME_LIMIT_EN undefined, sim_finish SHALL be constant 0 and no comparator logic SHALL exist.

Verification
REQ-035 Defaults, 3 vs falling edges -> frame_cnt=3; 3 vs_fall pulses, each 1 cycle; dump_on=1 from cycle 2 after reset; one dump_start.
REQ-036 START_FRAME=5, DUMP_FRAMES=2 -> dump_on rises with frame_cnt=5; st=DONE and dump_on=0 when frame_cnt=7.
REQ-037 WAIT_DWNLD=1, dwnld high for 100 cycles then low -> st stays IDLE until the dwnld fall, then ARMED; a second dwnld rise during DUMP -> st=IDLE, dump_on=0.
REQ-038 FRAME_LIMIT_EN defined, MAX_FRAMES=4 -> sim_finish rises with frame_cnt=4 and stays high through frame 6; undefined -> sim_finish=0 throughout.
REQ-039 rst_n low for 1 cycle mid-DUMP with vs low -> all outputs zero; the next counted frame requires a vs rise then fall.
REQ-040 Force frame_cnt near saturation -> frame_cnt holds at 32'hFFFF_FFFF with no wrap.
